// File: rtl/cam_power_seq.sv
// Camera sensor power sequencer.
// Walks the sensor through power-down release, reset release and a settle
// period before reporting it ready. It runs the reverse sequence on shutdown
// and a full power cycle on restart. Every output comes straight from a
// flop and updates on the same edge as the state it belongs to.
module cam_power_seq #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned T_PWDN_US   = 6000,
    parameter int unsigned T_RST_US    = 2000,
    parameter int unsigned T_INIT_US   = 21000,
    parameter int unsigned T_OFF_US    = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       restart,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       power_done,
    output logic       done_pulse,
    output logic [2:0] state
);

    localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned N_PWDN = CYC_PER_US * T_PWDN_US;
    localparam int unsigned N_RST  = CYC_PER_US * T_RST_US;
    localparam int unsigned N_INIT = CYC_PER_US * T_INIT_US;
    localparam int unsigned N_OFF  = CYC_PER_US * T_OFF_US;

    localparam int unsigned N_MAX_A = (N_PWDN > N_RST)  ? N_PWDN : N_RST;
    localparam int unsigned N_MAX_B = (N_INIT > N_OFF)  ? N_INIT : N_OFF;
    localparam int unsigned N_MAX   = (N_MAX_A > N_MAX_B) ? N_MAX_A : N_MAX_B;
    localparam int unsigned CW      = $clog2(N_MAX) + 1;

    // Terminal counts: the counter reads N-1 on the last cycle of a dwell,
    // so the state is left exactly N edges after it was entered.
    localparam logic [CW-1:0] LAST_PWDN = CW'(N_PWDN - 1);
    localparam logic [CW-1:0] LAST_RST  = CW'(N_RST - 1);
    localparam logic [CW-1:0] LAST_INIT = CW'(N_INIT - 1);
    localparam logic [CW-1:0] LAST_OFF  = CW'(N_OFF - 1);

    // Reject clock rates that are not whole MHz and dwell times that round to zero cycles.
    if ((CLK_FREQ_HZ % 1_000_000) != 0 || N_PWDN < 1 || N_RST < 1 ||
        N_INIT < 1 || N_OFF < 1) begin : g_bad_params
        $error("cam_power_seq: CLK_FREQ_HZ must be a multiple of 1 MHz and every dwell must be >= 1 cycle");
    end

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PWDN  = 3'd1,
        S_RST   = 3'd2,
        S_INIT  = 3'd3,
        S_READY = 3'd4,
        S_SHUT  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cam_pwdn_q, cam_pwdn_d;
    logic          cam_rst_n_q, cam_rst_n_d;
    logic          power_done_q, power_done_d;
    logic          done_pulse_q, done_pulse_d;

    // State register, dwell counter and registered pin values.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only, so it appears in the
        // body of the clocked block and not in the sensitivity list. State
        // updates use <= so every flop sees the values from before the edge.
        if (!rst_n) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            cam_pwdn_q   <= 1'b1;
            cam_rst_n_q  <= 1'b0;
            power_done_q <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cam_pwdn_q   <= cam_pwdn_d;
            cam_rst_n_q  <= cam_rst_n_d;
            power_done_q <= power_done_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Next state, dwell counter and the pin values that belong to the next state.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave a signal unassigned and create a latch.
        state_d      = state_q;
        cnt_d        = '0;
        cam_pwdn_d   = 1'b1;
        cam_rst_n_d  = 1'b0;
        power_done_d = 1'b0;
        done_pulse_d = 1'b0;

        unique case (state_q)
            S_OFF: begin
                if (en) state_d = S_PWDN;
            end
            S_PWDN: begin
                if (!en)                    state_d = S_OFF;
                else if (cnt_q == LAST_PWDN) state_d = S_RST;
            end
            S_RST: begin
                if (!en)                    state_d = S_SHUT;
                else if (cnt_q == LAST_RST) state_d = S_INIT;
            end
            S_INIT: begin
                if (!en)                     state_d = S_SHUT;
                else if (cnt_q == LAST_INIT) state_d = S_READY;
            end
            S_READY: begin
                // A low en and a restart pulse both lead to SHUT, so en takes
                // priority without needing its own branch.
                if (!en || restart) state_d = S_SHUT;
            end
            S_SHUT: begin
                if (cnt_q == LAST_OFF) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase

        // The counter clears on every state entry. It only runs in timed
        // states, where it stops at the terminal count, so it never wraps.
        if (state_d == state_q &&
            (state_q == S_PWDN || state_q == S_RST ||
             state_q == S_INIT || state_q == S_SHUT)) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_d)
            S_OFF, S_PWDN: begin
                cam_pwdn_d  = 1'b1;
                cam_rst_n_d = 1'b0;
            end
            S_RST, S_SHUT: begin
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b0;
            end
            S_INIT: begin
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
            end
            S_READY: begin
                cam_pwdn_d   = 1'b0;
                cam_rst_n_d  = 1'b1;
                power_done_d = 1'b1;
                done_pulse_d = (state_q != S_READY);
            end
            default: begin
                cam_pwdn_d  = 1'b1;
                cam_rst_n_d = 1'b0;
            end
        endcase
    end

    assign cam_pwdn   = cam_pwdn_q;
    assign cam_rst_n  = cam_rst_n_q;
    assign power_done = power_done_q;
    assign done_pulse = done_pulse_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cam_power_seq.sv
// Testbench for cam_power_seq using short dwell times (6/2/21/3 us at 1 MHz).
// Each scenario drives one input vector per clock. A cycle-level behavioural
// model tracks the phase and its age in cycles, and the bench compares the
// model with the DUT on every edge. It also checks the edge numbers of the
// documented power-up timing.
module tb_cam_power_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       restart;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       power_done;
    logic       done_pulse;
    logic [2:0] state;

    int vectors    = 0;
    int miscompares = 0;

    cam_power_seq #(
        .CLK_FREQ_HZ(1_000_000),
        .T_PWDN_US  (6),
        .T_RST_US   (2),
        .T_INIT_US  (21),
        .T_OFF_US   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .restart   (restart),
        .cam_pwdn  (cam_pwdn),
        .cam_rst_n (cam_rst_n),
        .power_done(power_done),
        .done_pulse(done_pulse),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Reference model: phase number (0=OFF .. 5=SHUT) plus cycles spent in it.
    int dur [6] = '{0, 6, 2, 21, 0, 3};
    int m_phase = 0;
    int m_age   = 0;
    bit m_pulse = 1'b0;

    task automatic model_step(input bit e, input bit r, input bit rn);
        int nxt;
        if (!rn) begin
            m_phase = 0;
            m_age   = 0;
            m_pulse = 1'b0;
            return;
        end
        nxt = m_phase;
        if (m_phase == 0) begin
            if (e) nxt = 1;
        end else if (m_phase == 1) begin
            if (!e) nxt = 0;
            else if (m_age + 1 == dur[1]) nxt = 2;
        end else if (m_phase == 2 || m_phase == 3) begin
            if (!e) nxt = 5;
            else if (m_age + 1 == dur[m_phase]) nxt = m_phase + 1;
        end else if (m_phase == 4) begin
            if (!e || r) nxt = 5;
        end else begin
            if (m_age + 1 == dur[5]) nxt = 0;
        end
        m_pulse = (nxt == 4) && (m_phase != 4);
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
    endtask

    // Expected {state, cam_pwdn, cam_rst_n, power_done, done_pulse}.
    function automatic logic [6:0] exp_vec();
        logic pw, rs, dn;
        pw = (m_phase <= 1);
        rs = (m_phase == 3) || (m_phase == 4);
        dn = (m_phase == 4);
        return {3'(m_phase), pw, rs, dn, m_pulse};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {state, cam_pwdn, cam_rst_n, power_done, done_pulse};
    endfunction

    // Apply one input vector, clock it in and advance the model; outputs are
    // sampled 1 ns after the edge.
    task automatic cycle(input bit e, input bit r, input bit rn);
        en      = e;
        restart = r;
        rst_n   = rn;
        @(posedge clk);
        model_step(e, r, rn);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'($urandom), 1'($urandom), 1'b0);
            vectors++;
            if (obs_vec() !== 7'b000_1_0_0_0) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs_vec(), 7'b000_1_0_0_0);
            end
        end
    endtask

    // Reset, then en=1 from edge 1; checks the documented edges. With rs set,
    // restart is held high throughout, which must not disturb the sequence.
    task automatic power_up(input bit rs, input string tag);
        cycle(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            cycle(1'b1, rs, 1'b1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s model edge %0d: got %b want %b", tag, k, obs_vec(), exp_vec());
            end
            if (k == 1 && state !== 3'd1) begin
                miscompares++;
                $display("FAIL %s pwdn_entry: state %0d want 1", tag, state);
            end
            if ((k == 6 && cam_pwdn !== 1'b1) || (k == 7 && cam_pwdn !== 1'b0)) begin
                miscompares++;
                $display("FAIL %s cam_pwdn edge %0d: got %b", tag, k, cam_pwdn);
            end
            if ((k == 8 && cam_rst_n !== 1'b0) || (k == 9 && cam_rst_n !== 1'b1)) begin
                miscompares++;
                $display("FAIL %s cam_rst_n edge %0d: got %b", tag, k, cam_rst_n);
            end
            if ((k == 29 && power_done !== 1'b0) ||
                (k == 30 && {power_done, done_pulse} !== 2'b11)) begin
                miscompares++;
                $display("FAIL %s done edge %0d: done %b pulse %b", tag, k, power_done, done_pulse);
            end
        end
        if (!rs) begin
            cycle(1'b1, 1'b0, 1'b1);
            vectors++;
            if ({state, power_done, done_pulse} !== {3'd4, 2'b10}) begin
                miscompares++;
                $display("FAIL %s edge31: state %0d done %b pulse %b want 4/1/0",
                         tag, state, power_done, done_pulse);
            end
        end
    endtask

    task automatic test_power_up();
        power_up(1'b0, "power_up");
    endtask

    task automatic test_shutdown();
        cycle(1'b0, 1'b0, 1'b1);
        vectors++;
        if ({state, cam_rst_n, power_done} !== {3'd5, 2'b00}) begin
            miscompares++;
            $display("FAIL shutdown entry: state %0d rst_n %b done %b want 5/0/0",
                     state, cam_rst_n, power_done);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL shutdown edge %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if ({state, cam_pwdn} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL shutdown off: state %0d pwdn %b want 0/1", state, cam_pwdn);
        end
    endtask

    task automatic test_restart();
        power_up(1'b0, "restart_pre");
        for (int i = 1; i <= 36; i++) begin
            cycle(1'b1, (i == 1), 1'b1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL restart edge %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if ((i == 3 && state !== 3'd5) || (i == 4 && state !== 3'd0) ||
                (i == 5 && state !== 3'd1) || (i == 34 && done_pulse !== 1'b1) ||
                (i == 35 && done_pulse !== 1'b0)) begin
                miscompares++;
                $display("FAIL restart seq edge %0d: state %0d pulse %b", i, state, done_pulse);
            end
        end
    endtask

    task automatic test_aborts();
        cycle(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cycle(k < 4, 1'b0, 1'b1);
            vectors++;
            if (cam_pwdn !== 1'b1 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL pwdn_abort edge %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (state !== 3'd0) begin
            miscompares++;
            $display("FAIL pwdn_abort final: state %0d want 0", state);
        end
        cycle(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cycle(k < 15, 1'b0, 1'b1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL init_abort edge %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if ((k == 15 && state !== 3'd5) || (k == 18 && state !== 3'd0)) begin
                miscompares++;
                $display("FAIL init_abort seq edge %0d: state %0d", k, state);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs_vec() !== 7'b000_1_0_0_0) begin
            miscompares++;
            $display("FAIL reset_mid: got %b want %b", obs_vec(), 7'b000_1_0_0_0);
        end
        power_up(1'b0, "reset_mid_rerun");
    endtask

    task automatic test_restart_ignored();
        power_up(1'b1, "restart_held");
        cycle(1'b1, 1'b1, 1'b1);
        vectors++;
        if (state !== 3'd5) begin
            miscompares++;
            $display("FAIL restart_held ready: state %0d want 5", state);
        end
        power_up(1'b0, "en_prio_pre");
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, (i == 1) ? 1'b1 : 1'($urandom), 1'b1);
            vectors++;
            if (obs_vec() !== exp_vec() || (i == 1 && state !== 3'd5) ||
                (i >= 4 && state !== 3'd0)) begin
                miscompares++;
                $display("FAIL en_priority edge %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit e = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) e = ~e;
            cycle(e, ($urandom_range(0, 19) == 0), ($urandom_range(0, 499) != 0));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        restart = 1'b0;
        test_reset();
        test_power_up();
        test_shutdown();
        test_restart();
        test_aborts();
        test_reset_mid();
        test_restart_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
